// File: rtl/lidar_feature_pkg.sv
// Shared types and constants for the LiDAR feature-extractor stages.
// Coordinates are signed Q16.16; the FSM encoding is used by the bounding-box accumulator.
package lidar_feature_pkg;

    localparam int COORD_W   = 32;
    localparam int FRAC_BITS = 16;
    localparam int NUM_AXES  = 3;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } point_t;

    typedef struct packed {
        coord_t min_x;
        coord_t min_y;
        coord_t min_z;
        coord_t max_x;
        coord_t max_y;
        coord_t max_z;
    } bbox_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/bbox_axis_update.sv
// Combinational min/max update for one axis; init seeds both bounds with the point.
module bbox_axis_update #(
    parameter int COORD_W = 32
) (
    input  logic signed [COORD_W-1:0] cur_min,
    input  logic signed [COORD_W-1:0] cur_max,
    input  logic signed [COORD_W-1:0] pt,
    input  logic                      init,
    output logic signed [COORD_W-1:0] nxt_min,
    output logic signed [COORD_W-1:0] nxt_max
);

    // Operands are all signed, so these are two's-complement compares.
    assign nxt_min = (init || (pt < cur_min)) ? pt : cur_min;
    assign nxt_max = (init || (pt > cur_max)) ? pt : cur_max;

endmodule

// File: rtl/bounding_box_accumulator.sv
// Streams one cluster of points and emits its axis-aligned bounding box and point count.
// min/max registers track the running box; the result is valid only in DONE.
module bounding_box_accumulator #(
    parameter int COORD_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    input  logic [COORD_W-1:0] pt_z,
    input  logic               pt_last,
    output logic               bbox_valid,
    input  logic               bbox_ready,
    output logic [COORD_W-1:0] min_x,
    output logic [COORD_W-1:0] min_y,
    output logic [COORD_W-1:0] min_z,
    output logic [COORD_W-1:0] max_x,
    output logic [COORD_W-1:0] max_y,
    output logic [COORD_W-1:0] max_z,
    output logic [CNT_W-1:0]   point_count,
    output logic               count_sat
);

    import lidar_feature_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    acc_state_t state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic             count_sat_reg;
    logic             accept;
    logic             init_pt;

    logic signed [COORD_W-1:0] pt_arr [NUM_AXES];
    logic signed [COORD_W-1:0] min_q  [NUM_AXES];
    logic signed [COORD_W-1:0] max_q  [NUM_AXES];

    assign pt_arr[0] = pt_x;
    assign pt_arr[1] = pt_y;
    assign pt_arr[2] = pt_z;

    // Gate with rst_n so the upstream never sees ready while reset is held.
    assign pt_ready   = rst_n && (state_reg != ST_DONE);
    assign bbox_valid = (state_reg == ST_DONE);
    assign accept     = pt_valid && pt_ready;
    assign init_pt    = (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_next = pt_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (bbox_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort wins over any accept or result handshake in the same cycle.
        if (clr) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            count_sat_reg <= 1'b0;
        end else if (clr) begin
            count_reg     <= '0;
            count_sat_reg <= 1'b0;
        end else if (accept) begin
            if (init_pt) begin
                count_reg     <= {{(CNT_W-1){1'b0}}, 1'b1};
                count_sat_reg <= 1'b0;
            end else if (count_reg == CNT_MAX) begin
                count_sat_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            logic signed [COORD_W-1:0] min_reg, max_reg;
            logic signed [COORD_W-1:0] nxt_min, nxt_max;

            bbox_axis_update #(
                .COORD_W (COORD_W)
            ) u_upd (
                .cur_min (min_reg),
                .cur_max (max_reg),
                .pt      (pt_arr[gi]),
                .init    (init_pt),
                .nxt_min (nxt_min),
                .nxt_max (nxt_max)
            );

            // clr leaves the bounds untouched; only a kept point moves them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    min_reg <= '0;
                    max_reg <= '0;
                end else if (accept && !clr) begin
                    min_reg <= nxt_min;
                    max_reg <= nxt_max;
                end
            end

            assign min_q[gi] = min_reg;
            assign max_q[gi] = max_reg;
        end
    endgenerate

    assign min_x       = min_q[0];
    assign min_y       = min_q[1];
    assign min_z       = min_q[2];
    assign max_x       = max_q[0];
    assign max_y       = max_q[1];
    assign max_z       = max_q[2];
    assign point_count = count_reg;
    assign count_sat   = count_sat_reg;

endmodule

// File: tb/tb_bounding_box_accumulator.sv
// Self-checking bench for bounding_box_accumulator (CNT_W=4 so saturation is reachable).
module tb_bounding_box_accumulator;

    localparam int TB_CNT_W = 4;
    localparam int OBS_W    = 6 * 32 + TB_CNT_W + 1;
    localparam int CNT_LIM  = (1 << TB_CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [31:0] pt_x = '0, pt_y = '0, pt_z = '0;
    logic        pt_last = 1'b0;
    logic        bbox_valid;
    logic        bbox_ready = 1'b0;
    logic [31:0] min_x, min_y, min_z, max_x, max_y, max_z;
    logic [TB_CNT_W-1:0] point_count;
    logic        count_sat;

    int n_vec = 0;
    int n_err = 0;

    // Points of the cluster under test, as plain signed integers.
    int cx[$];
    int cy[$];
    int cz[$];

    bounding_box_accumulator #(
        .COORD_W (32),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .pt_z        (pt_z),
        .pt_last     (pt_last),
        .bbox_valid  (bbox_valid),
        .bbox_ready  (bbox_ready),
        .min_x       (min_x),
        .min_y       (min_y),
        .min_z       (min_z),
        .max_x       (max_x),
        .max_y       (max_y),
        .max_z       (max_z),
        .point_count (point_count),
        .count_sat   (count_sat)
    );

    always #5 clk = ~clk;

    function automatic logic [OBS_W-1:0] observed();
        return {min_x, min_y, min_z, max_x, max_y, max_z, point_count, count_sat};
    endfunction

    // Reference: bounding box of the queued points, count clipped at the counter limit.
    function automatic logic [OBS_W-1:0] model_bbox();
        int mnx, mny, mnz, mxx, mxy, mxz, n;
        logic [31:0] a, b, c, d, e, f;
        logic [TB_CNT_W-1:0] cnt;
        logic sat;
        n = cx.size();
        mnx = cx[0]; mxx = cx[0];
        mny = cy[0]; mxy = cy[0];
        mnz = cz[0]; mxz = cz[0];
        foreach (cx[i]) begin
            if (cx[i] < mnx) mnx = cx[i];
            if (cx[i] > mxx) mxx = cx[i];
            if (cy[i] < mny) mny = cy[i];
            if (cy[i] > mxy) mxy = cy[i];
            if (cz[i] < mnz) mnz = cz[i];
            if (cz[i] > mxz) mxz = cz[i];
        end
        a = mnx; b = mny; c = mnz; d = mxx; e = mxy; f = mxz;
        cnt = TB_CNT_W'((n > CNT_LIM) ? CNT_LIM : n);
        sat = (n > CNT_LIM);
        return {a, b, c, d, e, f, cnt, sat};
    endfunction

    function automatic int rand_coord();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'sh8000_0000;
        if (r == 1) return 32'sh7FFF_FFFF;
        return $urandom;
    endfunction

    task automatic clear_cluster();
        cx.delete(); cy.delete(); cz.delete();
    endtask

    task automatic add_point(input int x, input int y, input int z);
        cx.push_back(x); cy.push_back(y); cz.push_back(z);
    endtask

    // Drives the queued points; returns one cycle after the final accept.
    task automatic send_cluster(input bit mark_last, input bit gaps);
        int w;
        for (int i = 0; i < cx.size(); i++) begin
            if (gaps) begin
                pt_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            pt_valid = 1'b1;
            pt_x = cx[i]; pt_y = cy[i]; pt_z = cz[i];
            pt_last = mark_last && (i == cx.size() - 1);
            w = 0;
            @(negedge clk);
            while (!pt_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!pt_ready) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: pt_ready=%0b required=1", pt_ready);
            end
            @(posedge clk);
            #1;
        end
        pt_valid = 1'b0;
        pt_last = 1'b0;
    endtask

    task automatic handshake();
        bbox_ready = 1'b1;
        @(posedge clk);
        #1;
        bbox_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({pt_ready, bbox_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ctrl: ready/valid=%b required=00", {pt_ready, bbox_valid});
        end
        n_vec++;
        if (observed() !== '0) begin
            n_err++;
            $display("FAIL reset_data: got=%h required=0", observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({pt_ready, bbox_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_idle: ready/valid=%b required=10", {pt_ready, bbox_valid});
        end
    endtask

    task automatic test_single_point();
        logic [OBS_W-1:0] exp;
        clear_cluster();
        add_point(32'sh0001_0000, 32'shFFFE_0000, 32'sh0000_8000);
        exp = model_bbox();
        send_cluster(1'b1, 1'b0);
        n_vec++;
        if (bbox_valid !== 1'b1 || pt_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency: valid=%0b ready=%0b required valid=1 ready=0", bbox_valid, pt_ready);
        end
        n_vec++;
        if (observed() !== exp) begin
            n_err++;
            $display("FAIL single_data: got=%h required=%h", observed(), exp);
        end
        handshake();
        n_vec++;
        if ({pt_ready, bbox_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL single_bubble: ready/valid=%b required=10", {pt_ready, bbox_valid});
        end
    endtask

    task automatic test_four_points_hold();
        logic [OBS_W-1:0] exp;
        clear_cluster();
        add_point(32'sh0003_0000, 0, 0);
        add_point(32'shFFFF_0000, 0, 0);
        add_point(32'sh0002_0000, 0, 0);
        add_point(32'shFFFC_0000, 0, 0);
        exp = model_bbox();
        send_cluster(1'b1, 1'b1);
        // Offer a stray point while the result is pending; it must not be taken.
        pt_valid = 1'b1; pt_x = 32'h0064_0000; pt_y = 32'h8000_0000; pt_z = 32'h7FFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (observed() !== exp || bbox_valid !== 1'b1 || pt_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got=%h v=%0b r=%0b required=%h v=1 r=0",
                         c, observed(), bbox_valid, pt_ready, exp);
            end
            @(posedge clk);
            #1;
        end
        pt_valid = 1'b0;
        handshake();
        n_vec++;
        if ({pt_ready, bbox_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL four_release: ready/valid=%b required=10", {pt_ready, bbox_valid});
        end
    endtask

    task automatic test_extremes();
        logic [OBS_W-1:0] exp;
        clear_cluster();
        add_point(32'sh7FFF_FFFF, 32'sh8000_0000, 0);
        add_point(32'sh8000_0000, 32'sh7FFF_FFFF, -1);
        exp = model_bbox();
        send_cluster(1'b1, 1'b0);
        n_vec++;
        if (observed() !== exp || bbox_valid !== 1'b1) begin
            n_err++;
            $display("FAIL extremes: got=%h v=%0b required=%h v=1", observed(), bbox_valid, exp);
        end
        handshake();
    endtask

    task automatic test_saturation();
        logic [OBS_W-1:0] exp;
        int sizes[3] = '{CNT_LIM, 20, 2};
        foreach (sizes[s]) begin
            clear_cluster();
            for (int i = 0; i < sizes[s]; i++) add_point(rand_coord(), rand_coord(), rand_coord());
            exp = model_bbox();
            send_cluster(1'b1, 1'b0);
            n_vec++;
            if (observed() !== exp || bbox_valid !== 1'b1) begin
                n_err++;
                $display("FAIL sat_n%0d: got=%h v=%0b required=%h v=1",
                         sizes[s], observed(), bbox_valid, exp);
            end
            handshake();
        end
    endtask

    task automatic test_clr();
        logic [OBS_W-1:0] exp;
        logic [191:0] box3;
        clear_cluster();
        add_point(32'sh0005_0000, 32'sh0001_0000, 32'shFFF0_0000);
        add_point(32'shFFFB_0000, 32'sh0002_0000, 32'sh0000_1000);
        add_point(32'sh0000_0100, 32'shFFFF_FFFF, 32'sh0000_0000);
        exp = model_bbox();
        box3 = exp[OBS_W-1 -: 192];
        send_cluster(1'b0, 1'b0);
        pt_valid = 1'b1; pt_last = 1'b1; clr = 1'b1;
        pt_x = 32'h7FFF_FFFF; pt_y = 32'h7FFF_FFFF; pt_z = 32'h8000_0000;
        @(posedge clk);
        #1;
        clr = 1'b0; pt_valid = 1'b0; pt_last = 1'b0;
        n_vec++;
        if (observed() !== {box3, {TB_CNT_W{1'b0}}, 1'b0} || {pt_ready, bbox_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL clr_abort: got=%h r/v=%b required=%h r/v=10",
                     observed(), {pt_ready, bbox_valid}, {box3, {TB_CNT_W{1'b0}}, 1'b0});
        end
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (bbox_valid !== 1'b0) begin
                n_err++;
                $display("FAIL clr_no_result%0d: bbox_valid=%0b required=0", c, bbox_valid);
            end
            @(posedge clk);
            #1;
        end
        clear_cluster();
        add_point(-7, 9, 32'sh8000_0000);
        exp = model_bbox();
        send_cluster(1'b1, 1'b0);
        n_vec++;
        if (observed() !== exp || bbox_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clr_next: got=%h v=%0b required=%h v=1", observed(), bbox_valid, exp);
        end
        // Abort beats a result handshake in the same cycle.
        bbox_ready = 1'b1; clr = 1'b1;
        @(posedge clk);
        #1;
        bbox_ready = 1'b0; clr = 1'b0;
        n_vec++;
        if ({pt_ready, bbox_valid, point_count, count_sat} !== {2'b10, {TB_CNT_W{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL clr_done: r/v/cnt/sat=%b required=%b",
                     {pt_ready, bbox_valid, point_count, count_sat}, {2'b10, {TB_CNT_W{1'b0}}, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        logic [OBS_W-1:0] exp;
        clear_cluster();
        add_point(32'sh0009_0000, 32'shFFF7_0000, 32'sh1234_5678);
        add_point(32'sh0001_0000, 32'sh0001_0000, 32'sh0000_0001);
        add_point(-5, 5, -5);
        send_cluster(1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (observed() !== '0 || {pt_ready, bbox_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset: got=%h r/v=%b required=0 r/v=00", observed(), {pt_ready, bbox_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({pt_ready, bbox_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL async_release: r/v=%b required=10", {pt_ready, bbox_valid});
        end
        clear_cluster();
        add_point(32'sh0002_0000, -3, 4);
        add_point(32'shFFFE_0000, 3, -4);
        exp = model_bbox();
        send_cluster(1'b1, 1'b0);
        n_vec++;
        if (observed() !== exp || bbox_valid !== 1'b1) begin
            n_err++;
            $display("FAIL async_next: got=%h v=%0b required=%h v=1", observed(), bbox_valid, exp);
        end
        handshake();
    endtask

    task automatic test_random();
        logic [OBS_W-1:0] exp;
        for (int k = 0; k < 30; k++) begin
            clear_cluster();
            for (int i = 0; i < $urandom_range(1, 20); i++)
                add_point(rand_coord(), rand_coord(), rand_coord());
            exp = model_bbox();
            send_cluster(1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            n_vec++;
            if (observed() !== exp || bbox_valid !== 1'b1 || pt_ready !== 1'b0) begin
                n_err++;
                $display("FAIL random%0d n=%0d: got=%h v=%0b r=%0b required=%h v=1 r=0",
                         k, cx.size(), observed(), bbox_valid, pt_ready, exp);
            end
            handshake();
            n_vec++;
            if ({pt_ready, bbox_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL random%0d_bubble: r/v=%b required=10", k, {pt_ready, bbox_valid});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_point();
        test_four_points_hold();
        test_extremes();
        test_saturation();
        test_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
